// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state codes, standard opcodes and the default IDCODE.
// The TAP state controller also uses these definitions.
package jtag_pkg;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_TEST_IDLE    = 4'd1,
      SELECT_DR        = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR        = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } tap_state_e;

   typedef enum logic [1:0] {
      SEL_BYPASS,
      SEL_IDCODE,
      SEL_USER
   } dr_sel_e;

   localparam logic [3:0]  OP_IDCODE  = 4'b0001;
   localparam logic [3:0]  OP_USER    = 4'b0010;
   localparam logic [3:0]  OP_BYPASS  = 4'b1111;
   localparam logic [31:0] IDCODE_VAL = 32'h1BA0_0477;

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift/update register: parallel capture, LSB-first serial shift,
// and a parallel hold register loaded from the shift stage on update.
module jtag_shift_reg #(
   parameter int unsigned  W       = 4,
   parameter logic [W-1:0] PAR_RST = '0
) (
   input  logic         TCK,
   input  logic         TRST,
   input  logic         clear,
   input  logic         capture,
   input  logic         shift,
   input  logic         update,
   input  logic [W-1:0] cap_val,
   input  logic         tdi,
   output logic         so,
   output logic [W-1:0] par
);

   logic [W-1:0] sr;
   logic [W-1:0] sr_nxt;

   // Split so a 1-bit register needs no reversed slice.
   assign sr_nxt[W-1] = tdi;
   if (W > 1) begin : g_wide
      assign sr_nxt[W-2:0] = sr[W-1:1];
   end

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         sr  <= '0;
         par <= PAR_RST;
      end else if (clear) begin
         sr  <= '0;
         par <= PAR_RST;
      end else begin
         if (capture) begin
            sr <= cap_val;
         end else if (shift) begin
            sr <= sr_nxt;
         end
         if (update) begin
            par <= sr;
         end
      end
   end

   assign so = sr[0];

endmodule

// File: rtl/tap_scan_regs.sv
// TCK-domain IR / BYPASS / IDCODE / user DR block behind the TAP state controller.
// State updates occur on the TCK rising edge. TDO and tdo_en are registered on the falling edge.
module tap_scan_regs
   import jtag_pkg::*;
#(
   parameter int unsigned     IR_W       = 4,
   parameter int unsigned     DR_W       = 16,
   parameter logic [31:0]     IDCODE_VAL = jtag_pkg::IDCODE_VAL,
   parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(jtag_pkg::OP_IDCODE),
   parameter logic [IR_W-1:0] OP_USER    = IR_W'(jtag_pkg::OP_USER)
) (
   input  logic            TCK,
   input  logic            TRST,
   input  logic [3:0]      tap_state,
   input  logic            TDI,
   input  logic [DR_W-1:0] user_capture,
   output logic            TDO,
   output logic            tdo_en,
   output logic [IR_W-1:0] ir_out,
   output logic [DR_W-1:0] user_dr,
   output logic            user_upd
);

   tap_state_e st;
   dr_sel_e    sel;
   logic       ir_so;
   logic       user_so;
   logic       user_sel;
   logic [31:0] id_sr;
   logic       bypass_bit;
   logic       tdo_nxt;
   logic       en_nxt;

   assign st = tap_state_e'(tap_state);

   // Every opcode other than IDCODE and USER selects the 1-bit bypass path.
   always_comb begin
      sel = SEL_BYPASS;
      if (ir_out == OP_IDCODE) begin
         sel = SEL_IDCODE;
      end else if (ir_out == OP_USER) begin
         sel = SEL_USER;
      end
   end

   assign user_sel = (sel == SEL_USER);

   jtag_shift_reg #(
      .W       (IR_W),
      .PAR_RST (OP_IDCODE)
   ) u_ir (
      .TCK     (TCK),
      .TRST    (TRST),
      .clear   (st == TEST_LOGIC_RESET),
      .capture (st == CAPTURE_IR),
      .shift   (st == SHIFT_IR),
      .update  (st == UPDATE_IR),
      .cap_val ({{(IR_W-2){1'b0}}, 2'b01}),
      .tdi     (TDI),
      .so      (ir_so),
      .par     (ir_out)
   );

   jtag_shift_reg #(
      .W       (DR_W),
      .PAR_RST ('0)
   ) u_user (
      .TCK     (TCK),
      .TRST    (TRST),
      .clear   (1'b0),
      .capture ((st == CAPTURE_DR) && user_sel),
      .shift   ((st == SHIFT_DR) && user_sel),
      .update  ((st == UPDATE_DR) && user_sel),
      .cap_val (user_capture),
      .tdi     (TDI),
      .so      (user_so),
      .par     (user_dr)
   );

   always_ff @(posedge TCK or posedge TRST) begin
      if (TRST) begin
         id_sr      <= '0;
         bypass_bit <= 1'b0;
         user_upd   <= 1'b0;
      end else begin
         user_upd <= (st == UPDATE_DR) && user_sel;
         if (st == CAPTURE_DR) begin
            if (sel == SEL_IDCODE) begin
               id_sr <= IDCODE_VAL;
            end else if (sel == SEL_BYPASS) begin
               bypass_bit <= 1'b0;
            end
         end else if (st == SHIFT_DR) begin
            if (sel == SEL_IDCODE) begin
               id_sr <= {TDI, id_sr[31:1]};
            end else if (sel == SEL_BYPASS) begin
               bypass_bit <= TDI;
            end
         end
      end
   end

   always_comb begin
      tdo_nxt = 1'b0;
      en_nxt  = 1'b0;
      case (st)
         SHIFT_IR: begin
            en_nxt  = 1'b1;
            tdo_nxt = ir_so;
         end
         SHIFT_DR: begin
            en_nxt = 1'b1;
            case (sel)
               SEL_IDCODE: tdo_nxt = id_sr[0];
               SEL_USER:   tdo_nxt = user_so;
               default:    tdo_nxt = bypass_bit;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(negedge TCK or posedge TRST) begin
      if (TRST) begin
         TDO    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         TDO    <= tdo_nxt;
         tdo_en <= en_nxt;
      end
   end

endmodule

// File: tb/tb_tap_scan_regs.sv
// Randomised scoreboard bench for tap_scan_regs. A queue-based scan-chain model predicts
// the TDO bits and user_dr updates, and independent monitors check them.
module tb_tap_scan_regs;

   localparam int unsigned IR_W = 4;
   localparam int unsigned DR_W = 16;
   localparam logic [31:0] EXP_IDCODE = 32'h1BA0_0477;
   localparam logic [3:0]  C_IDCODE = 4'b0001;
   localparam logic [3:0]  C_USER   = 4'b0010;

   localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SELDR = 4'd2,  S_CAPDR = 4'd3;
   localparam logic [3:0] S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PDR = 4'd6,   S_EX2DR = 4'd7;
   localparam logic [3:0] S_UPDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11;
   localparam logic [3:0] S_EX1IR = 4'd12, S_UPIR = 4'd15;

   logic            TCK = 1'b0;
   logic            TRST = 1'b0;
   logic [3:0]      tap_state = 4'd0;
   logic            TDI = 1'b0;
   logic [DR_W-1:0] user_capture = '0;
   logic            TDO;
   logic            tdo_en;
   logic [IR_W-1:0] ir_out;
   logic [DR_W-1:0] user_dr;
   logic            user_upd;

   int errors = 0;
   int checks = 0;

   bit              tdo_q[$];
   logic [DR_W-1:0] upd_q[$];
   bit              ir_chain[$];
   bit              dr_chain[$];
   logic [IR_W-1:0] m_ir = C_IDCODE;
   logic [DR_W-1:0] m_user = '0;

   always #5 TCK = ~TCK;

   tap_scan_regs #(
      .IR_W (IR_W),
      .DR_W (DR_W)
   ) dut (
      .TCK          (TCK),
      .TRST         (TRST),
      .tap_state    (tap_state),
      .TDI          (TDI),
      .user_capture (user_capture),
      .TDO          (TDO),
      .tdo_en       (tdo_en),
      .ir_out       (ir_out),
      .user_dr      (user_dr),
      .user_upd     (user_upd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack(input bit q[$]);
      logic [63:0] v = '0;
      foreach (q[i]) v[i] = q[i];
      return v;
   endfunction

   task automatic model_reset();
      m_ir   = C_IDCODE;
      m_user = '0;
      ir_chain = {};
      repeat (IR_W) ir_chain.push_back(1'b0);
      dr_chain = {};
   endtask

   // Drives one TAP state for one TCK cycle and advances the model. Call at posedge+1.
   task automatic step(input logic [3:0] s, input bit tdi);
      logic [31:0] cap;
      bit          upd;
      upd = 1'b0;
      tap_state = s;
      TDI = tdi;
      case (s)
         S_TLR: begin
            m_ir = C_IDCODE;
            ir_chain = {};
            repeat (IR_W) ir_chain.push_back(1'b0);
         end
         S_CAPIR: begin
            ir_chain = {};
            ir_chain.push_back(1'b1);
            repeat (IR_W - 1) ir_chain.push_back(1'b0);
         end
         S_SHIR: begin
            tdo_q.push_back(ir_chain.pop_front());
            ir_chain.push_back(tdi);
         end
         S_UPIR: m_ir = IR_W'(pack(ir_chain));
         S_CAPDR: begin
            dr_chain = {};
            if (m_ir == C_IDCODE) begin
               cap = EXP_IDCODE;
               for (int i = 0; i < 32; i++) dr_chain.push_back(cap[i]);
            end else if (m_ir == C_USER) begin
               cap = 32'(user_capture);
               for (int i = 0; i < int'(DR_W); i++) dr_chain.push_back(cap[i]);
            end else begin
               dr_chain.push_back(1'b0);
            end
         end
         S_SHDR: begin
            tdo_q.push_back(dr_chain.pop_front());
            dr_chain.push_back(tdi);
         end
         S_UPDR: begin
            if (m_ir == C_USER) begin
               m_user = DR_W'(pack(dr_chain));
               upd = 1'b1;
            end
         end
         default: ;
      endcase
      @(posedge TCK);
      #1;
      if (upd) upd_q.push_back(m_user);
      check("ir_out", 32'(ir_out), 32'(m_ir));
      check("user_dr", 32'(user_dr), 32'(m_user));
   endtask

   task automatic ir_scan(input int unsigned n, input logic [63:0] data);
      step(S_SELDR, 1'b0);
      step(S_SELIR, 1'b0);
      step(S_CAPIR, 1'b0);
      for (int unsigned i = 0; i < n; i++) step(S_SHIR, data[i]);
      step(S_EX1IR, 1'b0);
      step(S_UPIR, 1'b0);
      step(S_RTI, 1'b0);
   endtask

   task automatic dr_scan(input int unsigned n, input logic [63:0] data, input int unsigned pause_at);
      step(S_SELDR, 1'b0);
      step(S_CAPDR, 1'b0);
      for (int unsigned i = 0; i < n; i++) begin
         if (i == pause_at && i != 0) begin
            step(S_EX1DR, 1'b0);
            repeat (3) step(S_PDR, 1'b0);
            step(S_EX2DR, 1'b0);
         end
         step(S_SHDR, data[i]);
      end
      step(S_EX1DR, 1'b0);
      step(S_UPDR, 1'b0);
      step(S_RTI, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ir_out"},   32'(ir_out),   32'(C_IDCODE));
      check({tag, "_user_dr"},  32'(user_dr),  32'd0);
      check({tag, "_user_upd"}, 32'(user_upd), 32'd0);
      check({tag, "_tdo"},      32'(TDO),      32'd0);
      check({tag, "_tdo_en"},   32'(tdo_en),   32'd0);
   endtask

   // TDO monitor: each enabled falling edge must match the next predicted bit.
   always @(negedge TCK) begin
      bit e;
      #1;
      if (tdo_en === 1'b1) begin
         if (tdo_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tdo_en: high with no shift expected at %0t", $time);
         end else begin
            e = tdo_q.pop_front();
            check("tdo", 32'(TDO), 32'(e));
         end
      end else begin
         if (tdo_q.size() != 0) begin
            void'(tdo_q.pop_front());
            checks++;
            errors++;
            $display("FAIL tdo_en: low (%b) where a shift was expected at %0t", tdo_en, $time);
         end
         check("tdo_idle", 32'(TDO), 32'd0);
      end
   end

   // Update monitor: each user_upd pulse must match one predicted user_dr load.
   always @(negedge TCK) begin
      logic [DR_W-1:0] e;
      #2;
      if (user_upd === 1'b1) begin
         if (upd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL user_upd: unexpected pulse, user_dr %h at %0t", user_dr, $time);
         end else begin
            e = upd_q.pop_front();
            check("upd_user_dr", 32'(user_dr), 32'(e));
         end
      end else if (upd_q.size() != 0) begin
         e = upd_q.pop_front();
         checks++;
         errors++;
         $display("FAIL user_upd: missing pulse, got %b expected 1 for %h", user_upd, e);
      end
   end

   initial begin
      logic [63:0] d;
      int unsigned n;
      model_reset();
      #1 TRST = 1'b1;
      #1 check_reset_outputs("por");
      @(posedge TCK);
      #1 TRST = 1'b0;
      step(S_TLR, 1'b0);
      step(S_RTI, 1'b0);

      // Read IDCODE after reset.
      dr_scan(32, 64'd0, 0);

      // IR load of all ones selects BYPASS, which gives a one-bit delay.
      ir_scan(4, 64'hF);
      check("ir_bypass", 32'(ir_out), 32'hF);
      dr_scan(3, 64'b101, 0);

      // USER write/read.
      ir_scan(4, 64'(C_USER));
      user_capture = 16'hA5C3;
      dr_scan(16, 64'h1234, 0);
      check("user_write", 32'(user_dr), 32'h1234);

      // Pausing mid-scan must give the same result as an uninterrupted scan.
      user_capture = 16'(($urandom));
      dr_scan(16, 64'hBEEF, 0);
      dr_scan(16, 64'h0000, 0);
      dr_scan(16, 64'hBEEF, 8);
      check("pause_user_dr", 32'(user_dr), 32'hBEEF);

      // Asynchronous reset between edges during a USER shift.
      step(S_SELDR, 1'b0);
      step(S_CAPDR, 1'b0);
      repeat (5) step(S_SHDR, 1'($urandom));
      #2 TRST = 1'b1;
      #1 check_reset_outputs("mid_rst");
      model_reset();
      tap_state = S_TLR;
      @(posedge TCK);
      #1 TRST = 1'b0;
      step(S_TLR, 1'b0);
      step(S_RTI, 1'b0);

      // Opcode 0111 is undefined and must act as BYPASS without touching user_dr.
      ir_scan(4, 64'(C_USER));
      dr_scan(16, 64'(16'($urandom)), 0);
      ir_scan(4, 64'b0111);
      d = {$urandom, $urandom};
      dr_scan(5, d, 0);
      check("undef_user_dr", 32'(user_dr), 32'(m_user));

      // Random scans, including over-length IR and DR shifts.
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 4))
            0: ir_scan(4, 64'(C_IDCODE));
            1: ir_scan(4, 64'(C_USER));
            2: ir_scan(4, 64'hF);
            default: ir_scan($urandom_range(4, 7), {$urandom, $urandom});
         endcase
         user_capture = 16'($urandom);
         d = {$urandom, $urandom};
         n = $urandom_range(1, 40);
         dr_scan(n, d, $urandom_range(0, n));
         if ($urandom_range(0, 5) == 0) step(S_TLR, 1'b0);
      end

      repeat (3) @(posedge TCK);
      #1;
      check("tdo_q_drained", 32'(tdo_q.size()), 32'd0);
      check("upd_q_drained", 32'(upd_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tap_scan_regs.md
# tap_scan_regs

TCK-domain instruction/data register block downstream of the TAP state controller. It consumes the 4-bit TAP state code plus TDI and implements the instruction register (IR), bypass register, IDCODE register and one user data register. It drives TDO and publishes the decoded instruction and user register contents to the rest of the debug logic.

## Interface
- IR_W, 4, instruction register width (≥2)
- DR_W, 16, user data register width (1..32)
- IDCODE_VAL, 32'h1BA0_0477, IDCODE capture value; bit 0 must be 1
- OP_IDCODE, 4'b0001, IDCODE opcode; OP_USER, 4'b0010, user DR opcode; all-ones = BYPASS
- TCK  in  1  test clock; all state updates on rising edge, TDO on falling edge
- TRST  in  1  reset TRST, asynchronous, active-high
- tap_state  in  4  current TAP state code: 0 Test_Logic_Reset, 1 Run_Test_Idle, 2 Select_DR, 3 Capture_DR, 4 Shift_DR, 5 Exit1_DR, 6 Pause_DR, 7 Exit2_DR, 8 Update_DR, 9 Select_IR, 10 Capture_IR, 11 Shift_IR, 12 Exit1_IR, 13 Pause_IR, 14 Exit2_IR, 15 Update_IR; stable around each TCK rising edge
- TDI  in  1  serial data in
- user_capture  in  DR_W  value loaded into the user shift register in Capture_DR
- TDO  out  1  serial data out
- tdo_en  out  1  high while TDO is valid (Shift_DR/Shift_IR)
- ir_out  out  IR_W  active instruction
- user_dr  out  DR_W  user data register (parallel hold)
- user_upd  out  1  one-TCK pulse when user_dr is loaded

## Operation
- Registers: ir_shift[IR_W], ir_out[IR_W], dr_shift[32], bypass_bit, user_dr[DR_W].
- Test_Logic_Reset (code 0), every rising edge: ir_out <= OP_IDCODE, ir_shift <= 0, user_dr is not altered.
- Capture_IR: ir_shift <= {0…0, 2'b01}.
- Shift_IR: ir_shift <= {TDI, ir_shift[IR_W-1:1]}; LSB is shifted out first.
- Update_IR: ir_out <= ir_shift.
- Capture_DR: behaviour depends on ir_out.
  - BYPASS or any undefined opcode: bypass_bit <= 0.
  - IDCODE: dr_shift <= IDCODE_VAL.
  - USER: dr_shift[DR_W-1:0] <= user_capture.
- Shift_DR: the selected register shifts right, with TDI entering at its MSB.
  - Bit 31 for IDCODE.
  - Bit DR_W-1 for USER.
  - bypass_bit <= TDI for BYPASS.
- Update_DR with ir_out == OP_USER: user_dr <= dr_shift[DR_W-1:0] and user_upd <= 1. user_upd is 0 on every other edge.
- All other states (Select, Exit1/2, Pause, Run_Test_Idle) hold every register.
- TDO source:
  - Shift_IR: ir_shift[0].
  - Shift_DR: dr_shift[0] (IDCODE/USER) or bypass_bit (BYPASS/undefined).
- Undefined opcodes behave exactly as BYPASS.

## Timing
- TRST asserted: ir_out = OP_IDCODE, ir_shift = 0, dr_shift = 0, bypass_bit = 0, user_dr = 0, user_upd = 0, TDO = 0, tdo_en = 0. All take effect immediately, without waiting for a TCK edge.
- TRST asserted mid-shift aborts the scan. Partially shifted data is discarded, and no user_upd is generated.
- TDO/tdo_en are registered on the TCK falling edge from the register state and tap_state. This gives the first shifted bit half a cycle after the Capture→Shift rising edge.
- tdo_en = 1 exactly while tap_state ∈ {4, 11}, sampled at the falling edge. Otherwise TDO = 0.
- Latency:
  - ir_out changes on the rising edge at which tap_state == 15.
  - user_dr and user_upd change on the rising edge at which tap_state == 8. user_upd is high for exactly one TCK.
- Pause/Exit2 → Shift resumes shifting without re-capture. Shift position is preserved.
- Shifting more than the register length wraps nothing: excess TDI bits push earlier ones out of TDO.
- An IR update takes effect for the next Capture_DR. It never affects a DR scan already in progress.

## Structure
- Shared package jtag_pkg:
  - 4-bit TAP state code constants (names as listed above), also used by the TAP controller.
  - Opcode constants OP_IDCODE, OP_USER, OP_BYPASS.
  - IDCODE_VAL default.
- One sub-module, jtag_shift_reg, parameterised by width: capture/shift/update-hold register with capture value, serial in, serial out.
  - Instantiated for the IR.
  - Instantiated for the user DR.
  - IDCODE and bypass stay inline.

## Test plan
- Reset scan: TRST pulse, then Capture_DR + 32 Shift_DR with TDI = 0. TDO must deliver 0x1BA00477 LSB-first, and tdo_en must be high for exactly 32 falling edges.
- IR load: Capture_IR, then 4 Shift_IR with TDI = 1,1,1,1, then Update_IR. Required response:
  - TDO during the shift = 1,0,0,0.
  - ir_out = 4'b1111.
  - A following DR scan of 1,0,1 gives TDO = 0,1,0 (one-bit delay).
- User write/read: load OP_USER, user_capture = 16'hA5C3, DR scan of 16 bits shifting in 16'h1234. Required response:
  - TDO = 16'hA5C3 LSB-first.
  - After Update_DR, user_dr = 16'h1234 and user_upd is high for exactly one TCK.
- Pause mid-scan: a USER scan that goes Shift×8, Exit1, Pause×3, Exit2, Shift×8, Update must give the same user_dr as an uninterrupted 16-bit scan.
- Async reset mid-shift: assert TRST between edges during Shift_DR of a USER scan. Required response:
  - All outputs reach their reset values before the next TCK edge.
  - user_upd never pulses.
  - ir_out = OP_IDCODE.
- Undefined opcode 4'b0111: a DR scan must behave as 1-bit bypass, and user_dr must remain unchanged.
